// File: rtl/alu_pkg.sv
// Types and constants shared by the ALU execute-stage units (adder, divider).
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    // Flag-vector bit positions, identical for every unit feeding the flag mux.
    localparam int FLAG_SF = 4;
    localparam int FLAG_CF = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_PF = 1;
    localparam int FLAG_ZF = 0;
    localparam int FLAG_W  = 5;

    function automatic logic [63:0] ALL_ONES(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] MIN_NEG(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// (WIDTH+1)-bit trial subtractor a - b computed as a + ~b + 1 with 4-bit
// carry-lookahead slices; borrow is the inverted final carry.
module div_trial_sub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           borrow
);
    localparam int NS = WIDTH / 4;

    logic [WIDTH:0] bn;
    logic [NS:0]    c;
    logic           p_top;
    logic           g_top;

    assign bn   = ~b;
    assign c[0] = 1'b1;

    for (genvar i = 0; i < NS; i++) begin : g_slice
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] cc;

        assign p     = a[4*i +: 4] ^ bn[4*i +: 4];
        assign g     = a[4*i +: 4] & bn[4*i +: 4];
        assign cc[0] = c[i];
        assign cc[1] = g[0] | (p[0] & c[i]);
        assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[i]);
        assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                     | (p[2] & p[1] & p[0] & c[i]);
        assign c[i+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                      | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c[i]);
        assign diff[4*i +: 4] = p ^ cc;
    end

    // The extra top bit sits above the last full slice.
    assign p_top       = a[WIDTH] ^ bn[WIDTH];
    assign g_top       = a[WIDTH] & bn[WIDTH];
    assign diff[WIDTH] = p_top ^ c[NS];
    assign borrow      = ~(g_top | (p_top & c[NS]));

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider. States: IDLE wait for start | CALC one trial
// subtraction per clock | FIX sign correction | DONE register results, pulse done.
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             SF,
    output logic             CF,
    output logic             OF,
    output logic             PF,
    output logic             ZF
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONES = WIDTH'(ALL_ONES(WIDTH));
    localparam logic [WIDTH-1:0] MNEG = WIDTH'(MIN_NEG(WIDTH));

    state_t              state;
    logic [WIDTH:0]      rem;
    logic [WIDTH-1:0]    dq;
    logic [WIDTH-1:0]    dmag;
    logic [CW-1:0]       cnt;
    logic                sign_q;
    logic                sign_r;
    logic                cf_r;
    logic                of_r;
    logic [FLAG_W-1:0]   flags;
    logic [WIDTH:0]      trial_a;
    logic [WIDTH:0]      trial_d;
    logic                trial_borrow;
    logic                dvd_neg;
    logic                dvs_neg;

    // dq holds the dividend magnitude; quotient bits shift in behind it.
    assign trial_a = {rem[WIDTH-1:0], dq[WIDTH-1]};

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .a      (trial_a),
        .b      ({1'b0, dmag}),
        .diff   (trial_d),
        .borrow (trial_borrow)
    );

    assign dvd_neg = op_signed & dividend[WIDTH-1];
    assign dvs_neg = op_signed & divisor[WIDTH-1];

    assign SF = flags[FLAG_SF];
    assign CF = flags[FLAG_CF];
    assign OF = flags[FLAG_OF];
    assign PF = flags[FLAG_PF];
    assign ZF = flags[FLAG_ZF];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            dq        <= '0;
            dmag      <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            cf_r      <= 1'b0;
            of_r      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            flags     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        cnt    <= '0;
                        cf_r   <= 1'b0;
                        of_r   <= 1'b0;
                        sign_q <= 1'b0;
                        sign_r <= 1'b0;
                        // Shortcuts preload final results and pass through FIX unchanged.
                        if (divisor == '0) begin
                            dq    <= ONES;
                            rem   <= {1'b0, dividend};
                            cf_r  <= 1'b1;
                            state <= FIX;
                        end else if (op_signed && dividend == MNEG && divisor == ONES) begin
                            dq    <= MNEG;
                            rem   <= '0;
                            of_r  <= 1'b1;
                            state <= FIX;
                        end else begin
                            dq     <= dvd_neg ? -dividend : dividend;
                            dmag   <= dvs_neg ? -divisor : divisor;
                            rem    <= '0;
                            sign_q <= dvd_neg ^ dvs_neg;
                            sign_r <= dvd_neg;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    busy <= 1'b1;
                    cnt  <= cnt + 1'b1;
                    dq   <= {dq[WIDTH-2:0], ~trial_borrow};
                    rem  <= trial_borrow ? trial_a : trial_d;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    busy <= 1'b1;
                    if (sign_q) begin
                        dq <= -dq;
                    end
                    if (sign_r) begin
                        rem <= -rem;
                    end
                    state <= DONE;
                end
                DONE: begin
                    busy           <= 1'b0;
                    done           <= 1'b1;
                    quotient       <= dq;
                    remainder      <= rem[WIDTH-1:0];
                    flags[FLAG_SF] <= dq[WIDTH-1];
                    flags[FLAG_CF] <= cf_r;
                    flags[FLAG_OF] <= of_r;
                    flags[FLAG_PF] <= ^dq;
                    flags[FLAG_ZF] <= (dq == '0);
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table plus reset/abort/ignored-start sequences.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_signed;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        SF, CF, OF, PF, ZF;

    seq_divider #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_signed (op_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .SF        (SF),
        .CF        (CF),
        .OF        (OF),
        .PF        (PF),
        .ZF        (ZF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        cf;
        logic        of;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic [4:0]  f;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   busy_from = 1000000;
    int   busy_to   = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Flag order {SF,CF,OF,PF,ZF}
    function automatic logic [4:0] flags_of(input logic [15:0] q, input logic cf, input logic of);
        return {q[15], cf, of, ^q, (q == 16'h0000)};
    endfunction

    always begin : mon
        exp_t e;
        @(posedge clk);
        cyc++;
        #2;
        chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_from && cyc <= busy_to)});
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", {16'd0, quotient}, {16'd0, e.q});
                chk("remainder", {16'd0, remainder}, {16'd0, e.r});
                chk("flags", {27'd0, SF, CF, OF, PF, ZF}, {27'd0, e.f});
                chk("latency", cyc, e.due);
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            chk("done_missing", {31'd0, done}, 32'd1);
            void'(sb.pop_front());
        end
    end

    task automatic launch(input vec_t v);
        exp_t e;
        int   s;
        op_signed = v.sgn;
        dividend  = v.a;
        divisor   = v.b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        s     = cyc;
        start = 1'b0;
        e.q   = v.q;
        e.r   = v.r;
        e.f   = flags_of(v.q, v.cf, v.of);
        e.due = s + v.lat;
        sb.push_back(e);
        busy_from = s + 1;
        busy_to   = s + v.lat - 1;
    endtask

    // Returns inside the done cycle, so a following launch is back-to-back.
    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #3;
        end
        if (sb.size() != 0) begin
            chk("idle_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_quotient"}, {16'd0, quotient}, 32'd0);
        chk({tag, "_remainder"}, {16'd0, remainder}, 32'd0);
        chk({tag, "_flags"}, {27'd0, SF, CF, OF, PF, ZF}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        vec_t tbl[14];
        vec_t v;
        int   s;

        //          sgn   dividend  divisor   quotient  remainder cf    of    lat
        tbl[0]  = '{1'b0, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0, 18};
        tbl[1]  = '{1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18};
        tbl[2]  = '{1'b0, 16'd1234, 16'h0000, 16'hFFFF, 16'd1234, 1'b1, 1'b0, 2};
        tbl[3]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 2};
        tbl[4]  = '{1'b0, 16'd3,    16'd7,    16'h0000, 16'h0003, 1'b0, 1'b0, 18};
        tbl[5]  = '{1'b0, 16'd49,   16'd7,    16'h0007, 16'h0000, 1'b0, 1'b0, 18};
        tbl[6]  = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18};
        tbl[7]  = '{1'b1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 18};
        tbl[8]  = '{1'b1, 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 18};
        tbl[9]  = '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 18};
        tbl[10] = '{1'b1, 16'hFFFB, 16'h0000, 16'hFFFF, 16'hFFFB, 1'b1, 1'b0, 2};
        tbl[11] = '{1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 18};
        tbl[12] = '{1'b0, 16'h1234, 16'h0010, 16'h0123, 16'h0004, 1'b0, 1'b0, 18};
        tbl[13] = '{1'b1, 16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 18};

        rst       = 1'b1;
        start     = 1'b0;
        op_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Entry 4 (3/7) is followed directly by 49/7 started in its done cycle.
        for (int i = 0; i < 14; i++) begin
            launch(tbl[i]);
            wait_idle();
        end

        // A second start mid-operation must not disturb 100/7.
        launch(tbl[0]);
        repeat (4) @(posedge clk);
        #1;
        op_signed = 1'b0;
        dividend  = 16'd5;
        divisor   = 16'd1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Abort 100/7 with reset: no done, outputs cleared.
        launch(tbl[0]);
        s = cyc;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        busy_to = s + 10;
        @(posedge clk);
        #1;
        chk_all_zero("abort");
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        v = '{1'b0, 16'd9, 16'd3, 16'h0003, 16'h0000, 1'b0, 1'b0, 18};
        launch(v);
        wait_idle();
        repeat (3) @(posedge clk);
        #3;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
